// File: rtl/mic_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : mic_spi_responder
// Brief    : SPI responder emulating the microphone ADC: FIFO-buffered samples
//            shifted out MSB-first on MISO, one sample per SS-low frame.
// Revision : 1.0
// ============================================================================
module mic_spi_responder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             btnC_n,
  input  logic             SCK,
  input  logic             SS,
  output logic             MISO,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             frame_done,
  output logic             frame_abort,
  output logic [7:0]       underrun_cnt
);

  localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam int c_RISE_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_ss_s1, r_ss_s2, r_ss_d;
  logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                w_full, w_empty, w_push, w_pop, w_in_load, w_underrun;
  logic [WIDTH-1:0]    w_load_data;

  logic [WIDTH-1:0]    r_shift;
  logic [WIDTH-1:0]    r_last;
  logic                r_miso;
  logic [c_RISE_W-1:0] r_rise_cnt;
  logic [7:0]          r_underrun;
  logic                r_done, r_abort;

  // Synchronizer flops reset to the idle levels so no stale edge survives reset
  always_ff @(posedge clk or negedge btnC_n) begin
    if (!btnC_n) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_ss_s1  <= 1'b1;
      r_ss_s2  <= 1'b1;
      r_ss_d   <= 1'b1;
    end else begin
      r_sck_s1 <= SCK;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_ss_s1  <= SS;
      r_ss_s2  <= r_ss_s1;
      r_ss_d   <= r_ss_s2;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_ss_rise  = r_ss_s2 & ~r_ss_d;
  assign w_ss_fall  = ~r_ss_s2 & r_ss_d;

  assign w_full       = (r_count == c_CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign sample_ready = ~w_full;
  assign w_push       = sample_valid & ~w_full;
  assign w_in_load    = (r_state == ST_LOAD);
  assign w_pop        = w_in_load & ~w_empty;
  assign w_underrun   = w_in_load & w_empty;
  assign w_load_data  = w_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge btnC_n) begin
    if (!btnC_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_fall) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = w_ss_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (w_ss_rise) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge btnC_n) begin
    if (!btnC_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_last     <= '0;
      r_miso     <= 1'b0;
      r_rise_cnt <= '0;
      r_underrun <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_done  <= (r_state == ST_SHIFT) && w_ss_rise && (r_rise_cnt == c_RISE_W'(WIDTH));
      r_abort <= w_ss_rise && ((r_state == ST_LOAD) ||
                 ((r_state == ST_SHIFT) && (r_rise_cnt != c_RISE_W'(WIDTH))));

      if (w_in_load) begin
        // An empty FIFO replays the previously transmitted sample
        r_shift    <= w_load_data;
        r_last     <= w_load_data;
        r_miso     <= w_load_data[WIDTH-1];
        r_rise_cnt <= '0;
        if (w_underrun && (r_underrun != 8'hFF)) begin
          r_underrun <= r_underrun + 8'd1;
        end
      end else if ((r_state == ST_SHIFT) && !w_ss_rise) begin
        if (w_sck_rise && (r_rise_cnt != c_RISE_W'(WIDTH))) begin
          r_rise_cnt <= r_rise_cnt + c_RISE_W'(1);
        end
        if (w_sck_fall) begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_miso  <= r_shift[WIDTH-2];
        end
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign MISO         = r_miso;
  assign frame_done   = r_done;
  assign frame_abort  = r_abort;
  assign underrun_cnt = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_mic_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_spi_responder
// Brief    : Self-checking bench: vector table, corner-case sequences and
//            randomized frames against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_mic_spi_responder;

  logic        clk = 1'b0;
  logic        btnC_n = 1'b0;
  logic        SCK = 1'b0;
  logic        SS = 1'b1;
  logic        MISO;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        frame_done;
  logic        frame_abort;
  logic [7:0]  underrun_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int done_cyc = 0;
  int abort_cyc = 0;

  logic [15:0] mq[$];
  logic [15:0] m_last;
  int          m_und;
  logic [31:0] cap;

  typedef struct {
    int          npush;
    logic [15:0] v0;
    logic [15:0] v1;
    int          nrise;
    logic [31:0] exp_cap;
    int          exp_done;
    int          exp_abort;
    int          exp_und;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  mic_spi_responder #(.DEPTH(4), .WIDTH(16)) dut (
    .clk          (clk),
    .btnC_n       (btnC_n),
    .SCK          (SCK),
    .SS           (SS),
    .MISO         (MISO),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .underrun_cnt (underrun_cnt)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1)  done_cyc++;
    if (frame_abort === 1'b1) abort_cyc++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    btnC_n = 1'b0;
    SS = 1'b1;
    SCK = 1'b0;
    sample_valid = 1'b0;
    wclk(3);
    btnC_n = 1'b1;
    wclk(3);
    mq.delete();
    m_last = '0;
    m_und = 0;
  endtask

  task automatic push_one(input logic [15:0] v);
    logic acc;
    acc = 1'b0;
    sample_in = v;
    sample_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      acc = sample_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    sample_valid = 1'b0;
    chk("push_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic start_frame();
    cap = '0;
    done_cyc = 0;
    abort_cyc = 0;
    SS = 1'b0;
    wclk(6);
  endtask

  task automatic run_rises(input int n);
    for (int i = 0; i < n; i++) begin
      cap = {cap[30:0], MISO};
      SCK = 1'b1;
      wclk(5);
      SCK = 1'b0;
      wclk(5);
    end
  endtask

  task automatic end_frame();
    SS = 1'b1;
    wclk(6);
  endtask

  // Master's view of a sample after n rising-edge captures: zeros follow the LSB
  function automatic logic [31:0] view(input logic [15:0] s, input int n);
    logic [31:0] w;
    w = {16'd0, s};
    if (n <= 16) return w >> (16 - n);
    return w << (n - 16);
  endfunction

  task automatic frame_check(input string nm, input int n);
    logic [15:0] s;
    if (mq.size() == 0) begin
      s = m_last;
      if (m_und < 255) m_und++;
    end else begin
      s = mq.pop_front();
    end
    m_last = s;
    start_frame();
    run_rises(n);
    end_frame();
    chk({nm, "_cap"}, cap, view(s, n));
    chk({nm, "_done"}, done_cyc, (n >= 16) ? 1 : 0);
    chk({nm, "_abort"}, abort_cyc, (n >= 16) ? 0 : 1);
    chk({nm, "_underrun"}, {24'd0, underrun_cnt}, m_und);
  endtask

  initial begin
    logic [15:0] fv[5];
    int          n;
    int          r;

    tbl[0] = '{1, 16'hA5C3, 16'h0000, 16, 32'h0000A5C3, 1, 0, 0};
    tbl[1] = '{0, 16'h0000, 16'h0000, 16, 32'h0000A5C3, 1, 0, 1};
    tbl[2] = '{1, 16'h1234, 16'h0000, 16, 32'h00001234, 1, 0, 1};
    tbl[3] = '{0, 16'h0000, 16'h0000, 16, 32'h00001234, 1, 0, 2};
    tbl[4] = '{1, 16'hFFFF, 16'h0000, 20, 32'h000FFFF0, 1, 0, 2};
    tbl[5] = '{2, 16'h8001, 16'h4C2E, 7,  32'h00000040, 0, 1, 2};
    tbl[6] = '{0, 16'h0000, 16'h0000, 16, 32'h00004C2E, 1, 0, 2};
    tbl[7] = '{1, 16'h0F0F, 16'h0000, 1,  32'h00000000, 0, 1, 2};
    tbl[8] = '{1, 16'h7FFE, 16'h0000, 16, 32'h00007FFE, 1, 0, 2};

    // Reset state
    do_reset();
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd1);
    chk("rst_underrun", {24'd0, underrun_cnt}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].npush > 0) push_one(tbl[i].v0);
      if (tbl[i].npush > 1) push_one(tbl[i].v1);
      start_frame();
      run_rises(tbl[i].nrise);
      end_frame();
      chk($sformatf("vec%0d_cap", i), cap, tbl[i].exp_cap);
      chk($sformatf("vec%0d_done", i), done_cyc, tbl[i].exp_done);
      chk($sformatf("vec%0d_abort", i), abort_cyc, tbl[i].exp_abort);
      chk($sformatf("vec%0d_underrun", i), {24'd0, underrun_cnt}, tbl[i].exp_und);
    end

    // FIFO fill with valid held high, sample_ready timing around LOAD
    do_reset();
    fv[0] = 16'hC001; fv[1] = 16'h2345; fv[2] = 16'h6789; fv[3] = 16'h9ABC; fv[4] = 16'hDEAD;
    sample_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample_in = fv[k];
      chk($sformatf("fill_ready%0d", k), {31'd0, sample_ready}, (k < 4) ? 32'd1 : 32'd0);
      wclk(1);
    end
    wclk(3);
    chk("full_ready", {31'd0, sample_ready}, 32'd0);
    sample_valid = 1'b0;
    cap = '0;
    done_cyc = 0;
    abort_cyc = 0;
    SS = 1'b0;
    wclk(3);
    chk("ready_in_load", {31'd0, sample_ready}, 32'd0);
    wclk(1);
    chk("ready_after_load", {31'd0, sample_ready}, 32'd1);
    chk("miso_msb", {31'd0, MISO}, {31'd0, fv[0][15]});
    wclk(2);
    run_rises(16);
    SS = 1'b1;
    wclk(2);
    chk("done_t2", {31'd0, frame_done}, 32'd0);
    wclk(1);
    chk("done_t3", {31'd0, frame_done}, 32'd1);
    wclk(1);
    chk("done_t4", {31'd0, frame_done}, 32'd0);
    wclk(2);
    chk("fill_cap", cap, {16'd0, fv[0]});
    mq.delete();
    mq.push_back(fv[1]);
    mq.push_back(fv[2]);
    mq.push_back(fv[3]);
    m_last = fv[0];
    m_und = 0;
    for (int k = 0; k < 4; k++) frame_check($sformatf("drain%0d", k), 16);

    // Reset in the middle of a frame
    do_reset();
    frame_check("empty_after_rst", 16);
    push_one(16'hBEEF);
    push_one(16'h1111);
    start_frame();
    run_rises(5);
    chk("miso_pre_reset", {31'd0, MISO}, 32'd1);
    done_cyc = 0;
    abort_cyc = 0;
    btnC_n = 1'b0;
    #1;
    chk("midrst_miso", {31'd0, MISO}, 32'd0);
    chk("midrst_ready", {31'd0, sample_ready}, 32'd1);
    chk("midrst_underrun", {24'd0, underrun_cnt}, 32'd0);
    SS = 1'b1;
    SCK = 1'b0;
    wclk(3);
    btnC_n = 1'b1;
    wclk(6);
    chk("midrst_no_abort", abort_cyc, 32'd0);
    mq.delete();
    m_last = '0;
    m_und = 0;
    frame_check("post_midrst", 16);

    // Underrun counter saturation over 300 empty frames
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (m_und < 255) m_und++;
      start_frame();
      end_frame();
      if (k == 99 || k == 254 || k == 299) begin
        chk($sformatf("sat_underrun%0d", k), {24'd0, underrun_cnt}, m_und);
      end
    end

    // Randomized pushes and frame lengths against the reference model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        chk("rand_ready", {31'd0, sample_ready}, (mq.size() < 4) ? 32'd1 : 32'd0);
        if (mq.size() < 4) begin
          push_one(16'($urandom));
          mq.push_back(sample_in);
        end
      end
      r = $urandom_range(0, 9);
      if (r < 5)      n = 16;
      else if (r < 7) n = $urandom_range(17, 22);
      else            n = $urandom_range(0, 15);
      frame_check($sformatf("rand%0d", it), n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
